rr_burst_sched: RTL



---
 rtl/rr_burst_sched.sv | 106 ++++++++++
 1 files changed

// File: rtl/rr_burst_sched.sv
// Round-robin burst scheduler: grants one requester ownership of a shared resource
// for a burst of beats, then resumes the search from the index after the last winner.
module rr_burst_sched #(
   parameter int NUM_OF_INPUT = 20,
   parameter int INPUT_NBITS  = 5,
   parameter int BURST_NBITS  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [NUM_OF_INPUT-1:0] i_req,
   input  logic                    i_en,
   input  logic                    i_res_rdy,
   input  logic [BURST_NBITS-1:0]  i_cfg_max_burst,
   output logic                    o_gnt_valid,
   output logic [INPUT_NBITS-1:0]  o_gnt_id,
   output logic [NUM_OF_INPUT-1:0] o_gnt_vec,
   output logic                    o_beat,
   output logic [BURST_NBITS-1:0]  o_burst_cnt,
   output logic                    o_release,
   output logic                    o_state
);

   typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [INPUT_NBITS-1:0] r_gnt_id;
   logic [INPUT_NBITS-1:0] r_last;
   logic [BURST_NBITS-1:0] r_burst_cnt;

   logic                   w_found;
   logic [INPUT_NBITS-1:0] w_winner;
   logic [INPUT_NBITS:0]   w_sum;
   logic                   w_owner_req;
   logic                   w_beat;
   logic [BURST_NBITS:0]   w_cnt_inc;
   logic                   w_limit_hit;
   logic                   w_release;
   logic                   w_grant;

   // Search last+1, last+2, ... with wrap; the sum is one bit wider so any NUM_OF_INPUT works.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int i = 1; i <= NUM_OF_INPUT; i++) begin
         w_sum = {1'b0, r_last} + (INPUT_NBITS+1)'(i);
         if (w_sum >= (INPUT_NBITS+1)'(NUM_OF_INPUT))
            w_sum = w_sum - (INPUT_NBITS+1)'(NUM_OF_INPUT);
         if (!w_found && i_req[w_sum[INPUT_NBITS-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[INPUT_NBITS-1:0];
         end
      end
   end

   // Handshake: a beat transfers in any cycle where gnt_valid, res_rdy and the owner's req are all high.
   assign w_owner_req = i_req[r_gnt_id];
   assign w_beat      = (r_state == ST_OWN) && i_res_rdy && w_owner_req;
   assign w_cnt_inc   = {1'b0, r_burst_cnt} + 1'b1;
   assign w_limit_hit = w_beat && (i_cfg_max_burst != '0) && (w_cnt_inc == {1'b0, i_cfg_max_burst});
   assign w_release   = (r_state == ST_OWN) && (!w_owner_req || w_limit_hit);
   assign w_grant     = (r_state == ST_IDLE) && i_en && w_found;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_grant)   w_state_nxt = ST_OWN;
         ST_OWN:  if (w_release) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_gnt_id    <= '0;
         r_last      <= INPUT_NBITS'(NUM_OF_INPUT-1);
         r_burst_cnt <= '0;
      end else if (w_grant) begin
         r_gnt_id    <= w_winner;
         r_last      <= w_winner;
         r_burst_cnt <= '0;
      end else if (w_release) begin
         r_burst_cnt <= '0;
      end else if (w_beat && (r_burst_cnt != '1)) begin
         r_burst_cnt <= r_burst_cnt + 1'b1;
      end
   end

   always_comb begin
      o_gnt_valid = (r_state == ST_OWN);
      o_gnt_id    = r_gnt_id;
      o_gnt_vec   = '0;
      if (r_state == ST_OWN) o_gnt_vec[r_gnt_id] = 1'b1;
      o_beat      = w_beat;
      o_burst_cnt = r_burst_cnt;
      o_release   = w_release;
      o_state     = r_state;
   end

endmodule
